// File: rtl/vga_buffer_reader_pkg.sv
// Shared 640x480@60 VGA timing constants and types for the frame-buffer scan-out path.
package vga_buffer_reader_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam logic VGA_SYNC_ACTIVE = 1'b0;

  // Both counters share one width; 10 bits covers the 800-clock line and 525-line frame.
  localparam int unsigned CNT_W = 10;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic in_img;
    logic fs;
  } vga_ctrl_t;

  localparam vga_ctrl_t CTRL_IDLE = '{
    hs:     ~VGA_SYNC_ACTIVE,
    vs:     ~VGA_SYNC_ACTIVE,
    de:     1'b0,
    in_img: 1'b0,
    fs:     1'b0
  };

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// VGA raster counters with raw sync/display-enable and line/frame end strobes.
module vga_timing_gen
  import vga_buffer_reader_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_h_cnt,
  output logic [CNT_W-1:0] o_v_cnt,
  output logic             o_hs,
  output logic             o_vs,
  output logic             o_de,
  output logic             o_line_end,
  output logic             o_frame_end
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEGIN = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEGIN = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > (2 ** CNT_W) || V_TOTAL > (2 ** CNT_W)) begin : g_chk_cnt_w
    $error("vga_timing_gen: raster totals exceed counter width");
  end

  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic             w_line_end;
  logic             w_frame_end;

  assign w_line_end  = (r_h_cnt == H_LAST);
  assign w_frame_end = w_line_end && (r_v_cnt == V_LAST);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (i_en) begin
      if (w_line_end) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_frame_end ? '0 : r_v_cnt + 1'b1;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end
    end
  end

  assign o_h_cnt     = r_h_cnt;
  assign o_v_cnt     = r_v_cnt;
  assign o_hs        = (r_h_cnt >= HS_BEGIN && r_h_cnt < HS_END) ? VGA_SYNC_ACTIVE
                                                                 : ~VGA_SYNC_ACTIVE;
  assign o_vs        = (r_v_cnt >= VS_BEGIN && r_v_cnt < VS_END) ? VGA_SYNC_ACTIVE
                                                                 : ~VGA_SYNC_ACTIVE;
  assign o_de        = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign o_line_end  = w_line_end;
  assign o_frame_end = w_frame_end;

endmodule

// File: rtl/vga_buffer_reader.sv
// Scans the camera frame buffer (registered-read EBR) out to VGA as SCALE-replicated greyscale,
// with sync and pixel data aligned through a fixed 2-stage pipeline.
module vga_buffer_reader
  import vga_buffer_reader_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter int unsigned IMG_W    = 32,
  parameter int unsigned IMG_H    = 32,
  parameter int unsigned SCALE    = 8,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 4
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] RDATA,
  output logic [ADDR_W-1:0] RADDR,
  output logic              RE,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              de,
  output logic              frame_start
);

  if (IMG_W * IMG_H > (2 ** ADDR_W)) begin : g_chk_addr
    $error("vga_buffer_reader: image does not fit the buffer address space");
  end
  if (IMG_W * SCALE > H_ACTIVE || IMG_H * SCALE > V_ACTIVE) begin : g_chk_fit
    $error("vga_buffer_reader: scaled image exceeds the active area");
  end
  if (SCALE < 1 || SCALE > 16) begin : g_chk_scale
    $error("vga_buffer_reader: SCALE must be 1..16");
  end
  if (DATA_W != 4) begin : g_chk_data
    $error("vga_buffer_reader: DATA_W must be 4 for the 4-bit colour outputs");
  end

  localparam int unsigned XW = clog2_min1(SCALE);
  localparam int unsigned CW = clog2_min1(IMG_W);
  localparam int unsigned RW = clog2_min1(IMG_H);

  localparam logic [XW-1:0]    SUB_LAST = XW'(SCALE - 1);
  localparam logic [CW-1:0]    COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0]    ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CNT_W-1:0] IMG_HPIX = CNT_W'(IMG_W * SCALE);
  localparam logic [CNT_W-1:0] IMG_VPIX = CNT_W'(IMG_H * SCALE);

  logic             r_run;
  logic [CNT_W-1:0] w_h_cnt;
  logic [CNT_W-1:0] w_v_cnt;
  logic             w_hs;
  logic             w_vs;
  logic             w_de;
  logic             w_line_end;
  logic             w_frame_end;
  logic             w_v_in;
  logic             w_in_img;

  logic [XW-1:0]     r_x_sub;
  logic [CW-1:0]     r_col;
  logic [XW-1:0]     r_y_sub;
  logic [RW-1:0]     r_row;
  logic [ADDR_W-1:0] r_row_base;

  vga_ctrl_t         w_ctrl0;
  vga_ctrl_t         r_ctrl1;
  logic [DATA_W-1:0] r_pix;
  logic              r_hs;
  logic              r_vs;
  logic              r_de;
  logic              r_fs;

  // Counters sit at (0,0) for one clock after release, so the first frame_start lands on edge 3.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .i_en        (r_run),
    .o_h_cnt     (w_h_cnt),
    .o_v_cnt     (w_v_cnt),
    .o_hs        (w_hs),
    .o_vs        (w_vs),
    .o_de        (w_de),
    .o_line_end  (w_line_end),
    .o_frame_end (w_frame_end)
  );

  assign w_v_in   = (w_v_cnt < IMG_VPIX);
  assign w_in_img = (w_h_cnt < IMG_HPIX) && w_v_in;

  // Counter-based addressing: row_base steps by IMG_W per source row instead of row*IMG_W.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_sub    <= '0;
      r_col      <= '0;
      r_y_sub    <= '0;
      r_row      <= '0;
      r_row_base <= '0;
    end else if (r_run) begin
      if (w_line_end) begin
        r_x_sub <= '0;
        r_col   <= '0;
        if (w_frame_end) begin
          r_y_sub    <= '0;
          r_row      <= '0;
          r_row_base <= '0;
        end else if (w_v_in) begin
          if (r_y_sub == SUB_LAST) begin
            r_y_sub <= '0;
            if (r_row == ROW_LAST) begin
              r_row      <= '0;
              r_row_base <= '0;
            end else begin
              r_row      <= r_row + 1'b1;
              r_row_base <= r_row_base + ADDR_W'(IMG_W);
            end
          end else begin
            r_y_sub <= r_y_sub + 1'b1;
          end
        end
      end else if (w_in_img) begin
        if (r_x_sub == SUB_LAST) begin
          r_x_sub <= '0;
          r_col   <= (r_col == COL_LAST) ? '0 : r_col + 1'b1;
        end else begin
          r_x_sub <= r_x_sub + 1'b1;
        end
      end
    end
  end

  assign RADDR = r_row_base + ADDR_W'(r_col);
  assign RE    = w_in_img && r_run;

  always_comb begin
    w_ctrl0 = CTRL_IDLE;
    if (r_run) begin
      w_ctrl0.hs     = w_hs;
      w_ctrl0.vs     = w_vs;
      w_ctrl0.de     = w_de;
      w_ctrl0.in_img = w_in_img;
      w_ctrl0.fs     = (w_h_cnt == '0) && (w_v_cnt == '0);
    end
  end

  // Stage 1 waits alongside the EBR read; stage 2 registers pixel and sync together.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl1 <= CTRL_IDLE;
      r_pix   <= '0;
      r_hs    <= ~VGA_SYNC_ACTIVE;
      r_vs    <= ~VGA_SYNC_ACTIVE;
      r_de    <= 1'b0;
      r_fs    <= 1'b0;
    end else begin
      r_ctrl1 <= w_ctrl0;
      r_pix   <= r_ctrl1.in_img ? RDATA : '0;
      r_hs    <= r_ctrl1.hs;
      r_vs    <= r_ctrl1.vs;
      r_de    <= r_ctrl1.de;
      r_fs    <= r_ctrl1.fs;
    end
  end

  assign vga_r       = r_pix;
  assign vga_g       = r_pix;
  assign vga_b       = r_pix;
  assign vga_hs      = r_hs;
  assign vga_vs      = r_vs;
  assign de          = r_de;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_buffer_reader.sv
// Directed bench for vga_buffer_reader on a reduced raster (64x44 total, 32x32 image, SCALE 4).
module tb_vga_buffer_reader;

  localparam int HA = 48, HF = 4, HSY = 8, HB = 4, HT = 64;
  localparam int VA = 36, VF = 2, VSY = 3, VB = 3, VT = 44;
  localparam int IW = 8, IH = 8, SC = 4, AW = 6, DW = 4;
  localparam int FRAME = HT * VT;

  logic          pclk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] rdata;
  logic [AW-1:0] raddr;
  logic          re;
  logic [3:0]    vr, vg, vb;
  logic          hs, vs, de, fs;

  logic [DW-1:0] mem [64];
  logic          we = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;

  int total = 0;
  int bad = 0;
  int t;
  bit cap_en = 1'b0;

  logic [AW-1:0] cap_addr [2][FRAME];
  logic          cap_re   [2][FRAME];
  logic [15:0]   cap_out  [2][FRAME];

  vga_buffer_reader #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HSY), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VSY), .V_BP (VB),
    .IMG_W (IW), .IMG_H (IH), .SCALE (SC), .ADDR_W (AW), .DATA_W (DW)
  ) dut (
    .pclk (pclk), .rst_n (rst_n), .RDATA (rdata), .RADDR (raddr), .RE (re),
    .vga_r (vr), .vga_g (vg), .vga_b (vb), .vga_hs (hs), .vga_vs (vs),
    .de (de), .frame_start (fs)
  );

  always #5 pclk = ~pclk;

  // Behavioural EBR: write port for the camera, 1-cycle registered read port for the DUT.
  always @(posedge pclk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

  always @(posedge pclk or negedge rst_n) begin
    if (!rst_n) t <= 0;
    else t <= t + 1;
  end

  // Counters hold raster position t-1; outputs show position t-3.
  always @(negedge pclk) begin
    int p0, p3;
    p0 = t - 1;
    p3 = t - 3;
    if (cap_en && rst_n) begin
      if (p0 >= 0 && p0 < 2 * FRAME) begin
        cap_addr[p0 / FRAME][p0 % FRAME] = raddr;
        cap_re[p0 / FRAME][p0 % FRAME]   = re;
      end
      if (p3 >= 0 && p3 < 2 * FRAME)
        cap_out[p3 / FRAME][p3 % FRAME] = {vr, vg, vb, de, hs, vs, fs};
    end
  end

  // Camera writer: rewrites the whole buffer as (a+5)&F during lines 32-33 of frame 0.
  initial begin
    int n;
    n = 0;
    while (t - 1 != 32 * HT && n < 20000) begin
      @(negedge pclk);
      n++;
    end
    for (int i = 0; i < 64; i++) begin
      we    = 1'b1;
      waddr = AW'(i);
      wdata = DW'(i + 5);
      @(negedge pclk);
    end
    we = 1'b0;
  end

  typedef struct {
    int          f;
    int          h;
    int          v;
    logic [5:0]  addr;
    logic        re;
    logic [11:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int f, int h, int v, int a, int r, int rgb, int d, int h_s,
                              int v_s, int f_s);
    vec_t x;
    x.f = f; x.h = h; x.v = v;
    x.addr = 6'(a); x.re = 1'(r); x.rgb = 12'(rgb);
    x.de = 1'(d); x.hs = 1'(h_s); x.vs = 1'(v_s); x.fs = 1'(f_s);
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_t(input int target, input string name);
    int n;
    n = 0;
    while (t < target && n < 20000) begin
      @(negedge pclk);
      n++;
    end
    if (t != target) begin
      total++;
      bad++;
      $display("FAIL %s: timeout at t=%0d want %0d", name, t, target);
    end
  endtask

  initial begin
    int hs_lo, vs_lo, de_n, rgb_bad, fs_n, re_n, re_out, nz0, nz1, xs, fs1;
    for (int i = 0; i < 64; i++) mem[i] <= DW'(i);
    mem[0] <= 4'hA;

    //      f  h   v  addr re rgb    de hs vs fs
    vecs.push_back(mk(0, 0,  0,  0, 1, 'hAAA, 1, 1, 1, 1));
    vecs.push_back(mk(0, 3,  0,  0, 1, 'hAAA, 1, 1, 1, 0));
    vecs.push_back(mk(0, 4,  0,  1, 1, 'h111, 1, 1, 1, 0));
    vecs.push_back(mk(0, 13, 0,  3, 1, 'h333, 1, 1, 1, 0));
    vecs.push_back(mk(0, 31, 0,  7, 1, 'h777, 1, 1, 1, 0));
    vecs.push_back(mk(0, 32, 0,  0, 0, 'h000, 1, 1, 1, 0));
    vecs.push_back(mk(0, 47, 0,  0, 0, 'h000, 1, 1, 1, 0));
    vecs.push_back(mk(0, 48, 0,  0, 0, 'h000, 0, 1, 1, 0));
    vecs.push_back(mk(0, 52, 0,  0, 0, 'h000, 0, 0, 1, 0));
    vecs.push_back(mk(0, 59, 0,  0, 0, 'h000, 0, 0, 1, 0));
    vecs.push_back(mk(0, 60, 0,  0, 0, 'h000, 0, 1, 1, 0));
    vecs.push_back(mk(0, 63, 3,  0, 0, 'h000, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0,  4,  8, 1, 'h888, 1, 1, 1, 0));
    vecs.push_back(mk(0, 5,  5,  9, 1, 'h999, 1, 1, 1, 0));
    vecs.push_back(mk(0, 22, 13, 29, 1, 'hDDD, 1, 1, 1, 0));
    vecs.push_back(mk(0, 31, 31, 63, 1, 'hFFF, 1, 1, 1, 0));
    vecs.push_back(mk(0, 32, 31, 56, 0, 'h000, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0,  32, 0, 0, 'h000, 1, 1, 1, 0));
    vecs.push_back(mk(0, 47, 35, 0, 0, 'h000, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0,  36, 0, 0, 'h000, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0,  38, 0, 0, 'h000, 0, 1, 0, 0));
    vecs.push_back(mk(0, 55, 40, 0, 0, 'h000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  41, 0, 0, 'h000, 0, 1, 1, 0));
    vecs.push_back(mk(0, 63, 43, 0, 0, 'h000, 0, 1, 1, 0));
    vecs.push_back(mk(1, 0,  0,  0, 1, 'h555, 1, 1, 1, 1));
    vecs.push_back(mk(1, 5,  5,  9, 1, 'hEEE, 1, 1, 1, 0));
    vecs.push_back(mk(1, 20, 10, 21, 1, 'hAAA, 1, 1, 1, 0));
    vecs.push_back(mk(1, 31, 31, 63, 1, 'h444, 1, 1, 1, 0));

    cap_en = 1'b1;
    repeat (10) @(negedge pclk);
    check("reset_outputs", 32'({raddr, re, vr, vg, vb, de, hs, vs, fs}),
          32'({6'd0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0}));
    rst_n = 1'b1;
    wait_t(2 * FRAME + 3, "two_frames");

    foreach (vecs[i]) begin
      int p;
      string nm;
      p  = vecs[i].v * HT + vecs[i].h;
      nm = $sformatf("f%0d(%0d,%0d)", vecs[i].f, vecs[i].h, vecs[i].v);
      check({nm, "_addr_re"}, 32'({cap_addr[vecs[i].f][p], cap_re[vecs[i].f][p]}),
            32'({vecs[i].addr, vecs[i].re}));
      check({nm, "_out"}, 32'(cap_out[vecs[i].f][p]),
            32'({vecs[i].rgb, vecs[i].de, vecs[i].hs, vecs[i].vs, vecs[i].fs}));
    end

    hs_lo = 0; vs_lo = 0; de_n = 0; rgb_bad = 0; fs_n = 0; re_n = 0; re_out = 0;
    nz0 = 0; nz1 = 0; xs = 0; fs1 = 0;
    for (int p = 0; p < FRAME; p++) begin
      logic [15:0] o;
      o = cap_out[0][p];
      if (!o[2]) hs_lo++;
      if (!o[1]) vs_lo++;
      if (o[3]) de_n++;
      if (o[0]) fs_n++;
      if (!o[3] && o[15:4] != 12'h0) rgb_bad++;
      if (o[15:4] != 12'h0) nz0++;
      if (cap_re[0][p]) re_n++;
      if (cap_re[0][p] && ((p % HT) >= IW * SC || (p / HT) >= IH * SC)) re_out++;
      if (cap_out[1][p][15:4] != 12'h0) nz1++;
      if (cap_out[1][p][0]) fs1++;
      if ($isunknown(cap_out[0][p]) || $isunknown(cap_out[1][p])) xs++;
    end
    check("hs_low_cycles", 32'(hs_lo), 32'(HSY * VT));
    check("vs_low_cycles", 32'(vs_lo), 32'(VSY * HT));
    check("de_cycles", 32'(de_n), 32'(HA * VA));
    check("rgb_without_de", 32'(rgb_bad), 0);
    check("frame_start_per_frame0", 32'(fs_n), 1);
    check("frame_start_per_frame1", 32'(fs1), 1);
    check("re_cycles", 32'(re_n), 32'(IW * IH * SC * SC));
    check("re_outside_window", 32'(re_out), 0);
    check("nonzero_px_frame0", 32'(nz0), 32'((64 - 3) * SC * SC));
    check("nonzero_px_frame1", 32'(nz1), 32'((64 - 4) * SC * SC));
    check("x_on_outputs", 32'(xs), 0);

    // Mid-line reset at raster (20,10) of frame 2; output then shows (18,10) = addr 20 -> 9.
    wait_t(2 * FRAME + 10 * HT + 20 + 1, "reset_point");
    check("pre_reset_px", 32'({vr, vg, vb, de}), 32'({12'h999, 1'b1}));
    cap_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'({raddr, re, vr, vg, vb, de, hs, vs, fs}),
          32'({6'd0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0}));
    repeat (3) @(negedge pclk);
    rst_n = 1'b1;
    @(negedge pclk);
    check("rel_edge1_addr_re", 32'({raddr, re}), 32'({6'd0, 1'b1}));
    check("rel_edge1_fs_de", 32'({fs, de}), 0);
    @(negedge pclk);
    check("rel_edge2_fs", 32'(fs), 0);
    @(negedge pclk);
    check("rel_edge3_fs_de_rgb", 32'({fs, de, vr, vg, vb}), 32'({1'b1, 1'b1, 12'h555}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
